// File: rtl/simon_data_out.sv
// SIMON output packetiser: packs one (or, with SIMON_PAIR_EN, two) finished blocks
// into a host packet of data words, sequence count byte and info byte.
module simon_data_out #(
  parameter int unsigned N    = 16,
  parameter logic [3:0]  MODE = 4'h0
) (
  input  logic                     clk,
  input  logic                     R,
  input  logic                     newDATA,
  input  logic [2*N-1:0]           outDATA,
  input  logic [7:0]               infoIN,
  output logic                     loadDATA,
  output logic                     out_newPKT,
  input  logic                     out_loadPKT,
  output logic                     out_donePKT,
  output logic [(N/2+2)*8-1:0]     out,
  output logic                     err
);

  localparam int unsigned BW = 2 * N;
  localparam int unsigned DW = 4 * N;

`ifdef SIMON_PAIR_EN
  typedef enum logic [1:0] {WAIT, PAIR, SEND} state_t;
`else
  typedef enum logic [1:0] {WAIT, SEND} state_t;
`endif

  state_t          state_q, state_d;
  logic [DW-1:0]   data_q, data_d;
  logic [7:0]      info_q, info_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            load_q, load_d;
  logic            new_q, new_d;
  logic            err_q, err_d;
  logic            done_q, done_d;
  logic            cap, illegal, pair_in;

`ifdef SIMON_PAIR_EN
  assign pair_in = infoIN[7];
  assign cap     = newDATA && !load_q && (state_q == WAIT || state_q == PAIR);
`else
  logic unused_info7;
  assign unused_info7 = infoIN[7];
  assign pair_in      = 1'b0;
  assign cap          = newDATA && !load_q && (state_q == WAIT);
`endif

  // Key blocks and already-packetised blocks must never reach the host.
  assign illegal = infoIN[5] | infoIN[4];

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      state_q <= WAIT;
      data_q  <= '0;
      info_q  <= '0;
      cnt_q   <= '0;
      load_q  <= 1'b0;
      new_q   <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      info_q  <= info_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      new_q   <= new_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    info_d  = info_q;
    cnt_d   = cnt_q;
    load_d  = 1'b0;
    new_d   = new_q;
    err_d   = 1'b0;
    case (state_q)
      WAIT: begin
        if (cap) begin
          load_d = 1'b1;
          if (illegal) begin
            err_d = 1'b1;
          end else begin
            data_d = {{BW{1'b0}}, outDATA};
            info_d = {pair_in, infoIN[6], 2'b01, MODE};
`ifdef SIMON_PAIR_EN
            if (pair_in) begin
              state_d = PAIR;
            end else begin
              state_d = SEND;
              new_d   = 1'b1;
            end
`else
            state_d = SEND;
            new_d   = 1'b1;
`endif
          end
        end
      end
`ifdef SIMON_PAIR_EN
      PAIR: begin
        if (cap) begin
          load_d = 1'b1;
          if (illegal) begin
            err_d = 1'b1;
          end else begin
            data_d[DW-1:BW] = outDATA;
            state_d         = SEND;
            new_d           = 1'b1;
          end
        end
      end
`endif
      SEND: begin
        if (out_loadPKT) begin
          new_d   = 1'b0;
          cnt_d   = cnt_q + 8'd1;
          state_d = WAIT;
        end
      end
      default: state_d = WAIT;
    endcase
    // Falls on the capturing edge, rises one edge after the host acknowledge.
    done_d = (state_q == WAIT) && !new_q && !(cap && !illegal);
  end

  assign loadDATA    = load_q;
  assign out_newPKT  = new_q;
  assign out_donePKT = done_q;
  assign err         = err_q;
  assign out         = {info_q, cnt_q, data_q};

endmodule

// File: tb/tb_simon_data_out.sv
// Directed bench for simon_data_out (N=16, MODE=0) with an expected-packet scoreboard.
module tb_simon_data_out;

  logic        clk = 1'b0;
  logic        R;
  logic        newDATA;
  logic [31:0] outDATA;
  logic [7:0]  infoIN;
  logic        loadDATA;
  logic        out_newPKT;
  logic        out_loadPKT;
  logic        out_donePKT;
  logic [79:0] out;
  logic        err;

  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  exp_cnt  = 8'h00;
  logic [79:0] exp_q[$];
  logic [79:0] last_pkt;

  simon_data_out #(.N(16), .MODE(4'h0)) dut (
    .clk(clk), .R(R), .newDATA(newDATA), .outDATA(outDATA), .infoIN(infoIN),
    .loadDATA(loadDATA), .out_newPKT(out_newPKT), .out_loadPKT(out_loadPKT),
    .out_donePKT(out_donePKT), .out(out), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_info(input logic [7:0] inf);
    logic p;
`ifdef SIMON_PAIR_EN
    p = inf[7];
`else
    p = 1'b0;
`endif
    return {p, inf[6], 2'b01, 4'h0};
  endfunction

  function automatic logic [79:0] mk(input logic [7:0] inf, input logic [7:0] cnt,
                                     input logic [31:0] hi, input logic [31:0] lo);
    return {inf, cnt, hi, lo};
  endfunction

  // Present a block until loadDATA pulses, then drop newDATA.
  task automatic drive_block(input logic [31:0] d, input logic [7:0] inf, input logic exp_err);
    logic got;
    got     = 1'b0;
    newDATA = 1'b1;
    outDATA = d;
    infoIN  = inf;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (loadDATA) got = 1'b1;
    end
    chk("load_seen", 80'(got), 80'(1'b1));
    chk("err_pulse", 80'(err), 80'(exp_err));
    newDATA = 1'b0;
    @(negedge clk);
    chk("load_one_cycle", 80'(loadDATA), 80'(1'b0));
    chk("err_one_cycle", 80'(err), 80'(1'b0));
  endtask

  task automatic check_pkt();
    logic [79:0] e;
    for (int i = 0; i < 10 && !out_newPKT; i++) @(negedge clk);
    chk("pkt_valid", 80'(out_newPKT), 80'(1'b1));
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard observed=empty expected=entry");
    end else begin
      e        = exp_q.pop_front();
      last_pkt = e;
      chk("pkt_out", out, e);
      chk("pkt_done_low", 80'(out_donePKT), 80'(1'b0));
    end
  endtask

  task automatic ack();
    out_loadPKT = 1'b1;
    @(negedge clk);
    out_loadPKT = 1'b0;
    chk("ack_new_clr", 80'(out_newPKT), 80'(1'b0));
    chk("ack_done_a", 80'(out_donePKT), 80'(1'b0));
    @(negedge clk);
    chk("ack_done_a1", 80'(out_donePKT), 80'(1'b1));
    exp_cnt = exp_cnt + 8'd1;
  endtask

  task automatic send_single(input logic [31:0] d, input logic [7:0] inf);
    drive_block(d, inf, 1'b0);
    exp_q.push_back(mk(exp_info(inf), exp_cnt, 32'h0, d));
    check_pkt();
    ack();
  endtask

  task automatic do_reset();
    R = 1'b1;
    @(negedge clk);
    @(negedge clk);
    R       = 1'b0;
    exp_cnt = 8'h00;
    @(negedge clk);
  endtask

  initial begin
    R = 1'b1; newDATA = 1'b0; outDATA = '0; infoIN = '0; out_loadPKT = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_load", 80'(loadDATA), 80'(1'b0));
    chk("rst_new", 80'(out_newPKT), 80'(1'b0));
    chk("rst_err", 80'(err), 80'(1'b0));
    chk("rst_done", 80'(out_donePKT), 80'(1'b1));
    chk("rst_out", out, 80'h0);
    R = 1'b0;
    @(negedge clk);

    // Single block, exact byte layout from the worked example.
    drive_block(32'h6877_6565, 8'h00, 1'b0);
    exp_q.push_back(80'h10_00_0000_0000_6877_6565);
    check_pkt();
    ack();

    // Reset while a packet is pending.
    drive_block(32'hdead_beef, 8'h00, 1'b0);
    chk("pend_new", 80'(out_newPKT), 80'(1'b1));
    R = 1'b1;
    #1;
    chk("midrst_new", 80'(out_newPKT), 80'(1'b0));
    chk("midrst_done", 80'(out_donePKT), 80'(1'b1));
    chk("midrst_out", out, 80'h0);
    chk("midrst_load", 80'(loadDATA), 80'(1'b0));
    @(negedge clk);
    R       = 1'b0;
    exp_cnt = 8'h00;
    @(negedge clk);
    send_single(32'h1234_5678, 8'h40);

    // Pair flag.
    do_reset();
`ifdef SIMON_PAIR_EN
    drive_block(32'haaaa_bbbb, 8'h80, 1'b0);
    chk("pair_no_new", 80'(out_newPKT), 80'(1'b0));
    chk("pair_done_low", 80'(out_donePKT), 80'(1'b0));
    drive_block(32'hcccc_dddd, 8'h80, 1'b0);
    exp_q.push_back(mk(8'h90, exp_cnt, 32'hcccc_dddd, 32'haaaa_bbbb));
    check_pkt();
    ack();
`else
    drive_block(32'haaaa_bbbb, 8'h80, 1'b0);
    exp_q.push_back(80'h10_00_0000_0000_aaaa_bbbb);
    check_pkt();
    ack();
    drive_block(32'hcccc_dddd, 8'h80, 1'b0);
    exp_q.push_back(80'h10_01_0000_0000_cccc_dddd);
    check_pkt();
    ack();
`endif

    // Illegal blocks, then a stray acknowledge in WAIT; count must not move.
    drive_block(32'h1111_2222, 8'h20, 1'b1);
    chk("ill_key_new", 80'(out_newPKT), 80'(1'b0));
    chk("ill_key_done", 80'(out_donePKT), 80'(1'b1));
    drive_block(32'h3333_4444, 8'h10, 1'b1);
    chk("ill_out_new", 80'(out_newPKT), 80'(1'b0));
    out_loadPKT = 1'b1;
    @(negedge clk);
    out_loadPKT = 1'b0;
    @(negedge clk);
    chk("stray_ack_done", 80'(out_donePKT), 80'(1'b1));
    send_single(32'h5555_6666, 8'h00);

    // Host backpressure with newDATA held high throughout.
    drive_block(32'h0f0f_f0f0, 8'h00, 1'b0);
    exp_q.push_back(mk(8'h10, exp_cnt, 32'h0, 32'h0f0f_f0f0));
    check_pkt();
    newDATA = 1'b1;
    outDATA = 32'h7777_8888;
    infoIN  = 8'h00;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_load", 80'(loadDATA), 80'(1'b0));
      chk("bp_out", out, last_pkt);
    end
    out_loadPKT = 1'b1;
    @(negedge clk);
    out_loadPKT = 1'b0;
    chk("bp_ack_new", 80'(out_newPKT), 80'(1'b0));
    chk("bp_ack_noload", 80'(loadDATA), 80'(1'b0));
    exp_cnt = exp_cnt + 8'd1;
    exp_q.push_back(mk(8'h10, exp_cnt, 32'h0, 32'h7777_8888));
    @(negedge clk);
    chk("bp_cap_a1", 80'(loadDATA), 80'(1'b1));
    newDATA = 1'b0;
    check_pkt();
    ack();

    // Count wrap over 257 packets from reset.
    do_reset();
    for (int k = 0; k < 257; k++) begin
      send_single($urandom, {1'b0, 1'($urandom_range(0, 1)), 6'h00});
    end
    chk("wrap_cnt_model", 80'(exp_cnt), 80'(8'h01));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
